// File: rtl/point_pkg.sv
// Shared constants and FSM encoding for the clean-point serializer.
package point_pkg;
    localparam int POINT_W      = 128;
    localparam int WORD_W       = 32;
    localparam int BEATS        = POINT_W / WORD_W;
    localparam int SUPPRESS_MSB = 127;
    localparam int SUPPRESS_LSB = 112;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/point_fifo.sv
// Point FIFO with combinational head read so the serializer can load the head on the pop edge.
module point_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage is not reset; clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/clean_point_serializer.sv
// Buffers cleaned radar points and streams each one as four words, least-significant first.
module clean_point_serializer
    import point_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic [POINT_W-1:0] clean_point,
    input  logic               drop_suppressed,
    input  logic               clear_stats,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    output logic               overflow,
    output logic [15:0]        drop_count,
    output logic [2:0]         fifo_level
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t             state;
    logic [POINT_W-1:0] shift;
    logic [1:0]         beat;
    logic [POINT_W-1:0] head;
    logic [LVL_W-1:0]   level;
    logic               full;
    logic               empty;
    logic               suppressed;
    logic               discard;
    logic               last_hs;
    logic               pop;
    logic               push;

    assign suppressed = (clean_point[SUPPRESS_MSB:SUPPRESS_LSB] == '0);
    assign discard    = valid_in && drop_suppressed && suppressed;
    assign last_hs    = (state == SEND) && out_ready && (beat == 2'(BEATS - 1));
    assign pop        = !empty && ((state == IDLE) || last_hs);
    // A full FIFO still takes a point when the head leaves on the same edge.
    assign push       = valid_in && !discard && (!full || pop);

    point_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (POINT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (clean_point),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign fifo_level = 3'(level);
    assign out_data   = shift[WORD_W*beat +: WORD_W];
    assign out_last   = (state == SEND) && (beat == 2'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift     <= '0;
            beat      <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift     <= head;
                        beat      <= '0;
                        state     <= SEND;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (beat != 2'(BEATS - 1)) begin
                            beat <= beat + 2'd1;
                        end else if (pop) begin
                            shift <= head;
                            beat  <= '0;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Clearing wins over any same-edge increment or overflow set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_stats) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (valid_in && !discard && full && !pop) begin
                overflow <= 1'b1;
            end
            if (discard && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_clean_point_serializer.sv
// Directed bench: stimulus queues expected beats, a negedge monitor checks every presented beat.
module tb_clean_point_serializer;
    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic [127:0] clean_point;
    logic         drop_suppressed;
    logic         clear_stats;
    logic         out_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_last;
    logic         overflow;
    logic [15:0]  drop_count;
    logic [2:0]   fifo_level;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    clean_point_serializer #(
        .DEPTH  (4),
        .WORD_W (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (valid_in),
        .clean_point     (clean_point),
        .drop_suppressed (drop_suppressed),
        .clear_stats     (clear_stats),
        .out_ready       (out_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_last        (out_last),
        .overflow        (overflow),
        .drop_count      (drop_count),
        .fifo_level      (fifo_level)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_point(input logic [127:0] p);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.data = p[32*i +: 32];
            b.last = (i == 3);
            sb.push_back(b);
        end
    endtask

    function automatic logic [127:0] mk_point(input logic [7:0] tag, input int i);
        logic [31:0] idx;
        idx = 32'(i);
        return {{tag, 24'h000300} | idx, {tag, 24'h000200} | idx,
                {tag, 24'h000100} | idx, {tag, 24'h000000} | idx};
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        valid_in = 1'b0;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout left %0d want 0", sb.size());
        end
        tick();
        tick();
        check("idle_after_drain", out_valid, 1'b0);
    endtask

    // Monitor: compares the queue head whenever a beat is presented, pops on handshake.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got data=%h last=%b want no beat", out_data, out_last);
            end else begin
                if (out_data !== sb[0].data || out_last !== sb[0].last) begin
                    errors++;
                    $display("FAIL beat got data=%h last=%b want data=%h last=%b",
                             out_data, out_last, sb[0].data, sb[0].last);
                end
                if (out_ready) begin
                    $display("beat data=%h last=%b", out_data, out_last);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p;
        reset           = 1'b1;
        valid_in        = 1'b0;
        clean_point     = '0;
        drop_suppressed = 1'b0;
        clear_stats     = 1'b0;
        out_ready       = 1'b0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_count", drop_count, 16'h0);
        check("rst_fifo_level", fifo_level, 3'd0);
        reset = 1'b0;
        tick();

        // Single point, latency and word order
        out_ready   = 1'b1;
        p           = 128'h00000004_00000003_00000002_00000001;
        clean_point = p;
        valid_in    = 1'b1;
        expect_point(p);
        tick();
        valid_in = 1'b0;
        check("lat_after_e1", out_valid, 1'b0);
        tick();
        check("lat_after_e2", out_valid, 1'b1);
        check("lat_first_word", out_data, 32'h1);
        drain(50);

        // Burst of six with downstream stalled: five kept, one lost
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p           = mk_point(8'hA0, i);
            clean_point = p;
            valid_in    = 1'b1;
            if (i < 5) expect_point(p);
            tick();
        end
        valid_in = 1'b0;
        check("burst_level", fifo_level, 3'd4);
        check("burst_overflow", overflow, 1'b1);
        out_ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #1;
        end
        check("burst_no_bubble", 32'(sb.size()), 32'd0);
        drain(10);

        // Suppressed point dropped, then passed through when dropping is off
        do_reset();
        out_ready       = 1'b1;
        drop_suppressed = 1'b1;
        p               = 128'h0000_1234_5678_9ABC_DEF0_1122_3344_5566;
        clean_point     = p;
        valid_in        = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        check("drop_count_one", drop_count, 16'd1);
        check("drop_level", fifo_level, 3'd0);
        check("drop_no_output", out_valid, 1'b0);
        drop_suppressed = 1'b0;
        valid_in        = 1'b1;
        expect_point(p);
        tick();
        valid_in = 1'b0;
        drain(50);
        check("drop_count_kept", drop_count, 16'd1);

        // Full FIFO, beat-3 handshake coincides with a new point
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p           = mk_point(8'hB0, i);
            clean_point = p;
            valid_in    = 1'b1;
            expect_point(p);
            tick();
        end
        valid_in = 1'b0;
        check("full_level", fifo_level, 3'd4);
        check("full_no_overflow", overflow, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        p           = mk_point(8'hC0, 9);
        clean_point = p;
        valid_in    = 1'b1;
        expect_point(p);
        tick();
        valid_in = 1'b0;
        check("pass_level", fifo_level, 3'd4);
        check("pass_overflow", overflow, 1'b0);
        drain(60);

        // Stall pattern 1,0,0,1 mid-packet
        do_reset();
        out_ready   = 1'b1;
        p           = mk_point(8'hD0, 3);
        clean_point = p;
        valid_in    = 1'b1;
        expect_point(p);
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        drain(20);

        // Reset at beat 2 aborts everything
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p           = mk_point(8'hE0, i);
            clean_point = p;
            valid_in    = 1'b1;
            expect_point(p);
            tick();
        end
        valid_in  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("pre_reset_data", out_data, 32'hE0000200);
        reset = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_last", out_last, 1'b0);
        check("mid_rst_level", fifo_level, 3'd0);
        check("mid_rst_data", out_data, 32'h0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", out_valid, 1'b0);

        // clear_stats beats a same-edge increment
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p           = mk_point(8'hF0, i);
            clean_point = p;
            valid_in    = 1'b1;
            if (i < 5) expect_point(p);
            tick();
        end
        drop_suppressed = 1'b1;
        clean_point     = 128'h0000_0000_0000_0000_0000_0000_0000_0077;
        tick();
        valid_in = 1'b0;
        check("stats_overflow", overflow, 1'b1);
        check("stats_drop", drop_count, 16'd1);
        valid_in    = 1'b1;
        clear_stats = 1'b1;
        tick();
        valid_in    = 1'b0;
        clear_stats = 1'b0;
        check("clr_overflow", overflow, 1'b0);
        check("clr_drop", drop_count, 16'd0);
        drop_suppressed = 1'b0;
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clean_point_serializer.md
CLEAN_POINT_SERIALIZER -- requirements
Module: clean_point_serializer

Interface
REQ-001 The block SHALL have one clock and asynchronous, active-high reset, named clk and reset.
REQ-002 Parameter DEPTH, default 4: point FIFO depth in entries; power of two, at least 2.
REQ-003 Parameter WORD_W, default 32: output beat width; POINT_W/WORD_W = BEATS = 4.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port valid_in, input, 1: clean_point is valid this cycle; no backpressure upstream.
REQ-007 Port clean_point, input, 128: cleaned radar point; bits [127:112] == 0 marks a suppressed point.
REQ-008 Port drop_suppressed, input, 1: when high, discard suppressed points.
REQ-009 Port clear_stats, input, 1: synchronous clear of overflow and drop_count.
REQ-010 Port out_ready, input, 1: downstream accepts the current beat.
REQ-011 Port out_valid, output, 1: out_data is a valid beat.
REQ-012 Port out_data, output, WORD_W: current beat.
REQ-013 Port out_last, output, 1: final beat of a point.
REQ-014 Port overflow, output, 1: sticky flag; a point was lost because the FIFO was full.
REQ-015 Port drop_count, output, 16: saturating count of suppressed points discarded.
REQ-016 Port fifo_level, output, 3: FIFO occupancy, 0..DEPTH.

Function
REQ-017 Accept: at a clk edge with valid_in=1, drop_suppressed=1 and clean_point[127:112]==0, the point SHALL be discarded and drop_count incremented, saturating at 16'hFFFF.
REQ-018 Otherwise, with valid_in=1, the point SHALL be written to the FIFO if fifo_level<DEPTH, or if the FIFO is full and a pop occurs at the same edge.
REQ-019 If the FIFO is full and there is no pop at the same edge, the point SHALL be discarded and overflow set to 1.
REQ-020 The serializer FSM SHALL have states IDLE and SEND, with a 128-bit shift register and a 2-bit beat counter.
REQ-021 IDLE: out_valid=0. If the FIFO is non-empty, the FSM SHALL pop the head into the shift register, set beat=0 and go to SEND.
REQ-022 SEND: out_valid=1, out_data=shift[WORD_W*beat +: WORD_W] (least-significant word first), and out_last=(beat==3).
REQ-023 In SEND, out_data and out_last SHALL remain stable while out_ready=0.
REQ-024 On a SEND handshake (out_valid & out_ready) with beat<3, beat SHALL increment.
REQ-025 On a SEND handshake with beat==3: if the FIFO is non-empty, the FSM SHALL pop the next point, set beat=0 and stay in SEND (no bubble); otherwise it SHALL go to IDLE.
REQ-026 Latency: a point written to an empty FIFO while IDLE at edge t SHALL appear as beat 0 after edge t+1.
REQ-027 Capacity: DEPTH points in the FIFO plus one in the shift register.
REQ-028 Simultaneous FIFO write and pop SHALL leave fifo_level unchanged.
REQ-029 fifo_level SHALL reflect occupancy after each edge.
REQ-030 clear_stats=1 SHALL zero overflow and drop_count at the next edge and take priority over a same-cycle increment or set.
REQ-031 Outputs SHALL be registered, except out_data and out_last, which decode the registered shift register and beat counter.

Reset
REQ-032 Reset SHALL force: state IDLE, FIFO empty, beat 0, shift register 0, out_valid 0, out_last 0, out_data 0, overflow 0, drop_count 0, fifo_level 0.
REQ-033 Reset mid-packet SHALL abort the packet with no out_last; no stored point survives reset.

Structure
REQ-034 Shared package point_pkg SHALL hold POINT_W=128, WORD_W, BEATS, the SUPPRESS_MSB/LSB field bounds (127/112) and the FSM state encoding.
REQ-035 The FIFO SHALL be a sub-module, point_fifo (parameters DEPTH and width), with push, pop, full, empty and level.

Verification
REQ-036 Single point 128'h0004_0003_0002_0001_..., out_ready=1 → four beats, LSW first, out_last on beat 4, first beat after 2 edges.
REQ-037 Burst of 6 back-to-back points with out_ready=0, DEPTH=4 → 5 points retained, overflow=1, fifo_level=4; after release, 20 beats with no bubble between points.
REQ-038 drop_suppressed=1 with point [127:112]=0 → no output, drop_count=1; with drop_suppressed=0, the same point is serialized.
REQ-039 FIFO full, beat 3 handshake coincides with valid_in → point accepted, overflow stays 0, fifo_level stays 4.
REQ-040 out_ready toggled 1,0,0,1 during a packet → out_data held stable while stalled; reset asserted at beat 2 → out_valid=0 and FIFO empty immediately; clear_stats zeroes overflow and drop_count.
